ysyx_23060332_lsu: RTL and testbench
====================================

Name: ysyx_23060332_lsu

Overview:
- Load/store unit directly upstream of the data-memory stage.
- Accepts one memory instruction at a time from EXU over a valid/ready handshake.
- Drives word-aligned read/write requests with byte-lane masks to the memory stage and consumes its registered read data one cycle later.
- Extracts and sign/zero-extends the load result, then presents it to WBU over a valid/ready handshake.

Parameters:
- ADDR_W, 32, address width (matches memory address bus).
- DATA_W, 32, data width (matches memory data bus; RV32).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- req_valid  input  1  EXU request valid
- req_ready  output  1  LSU can accept (high only in IDLE)
- req_load  input  1  request is a load
- req_store  input  1  request is a store
- req_funct3  input  3  RV32 load/store funct3
- req_addr  input  ADDR_W  effective byte address
- req_wdata  input  DATA_W  store source (rs2), LSB-justified
- req_rd  input  5  load destination register
- mem_ren  output  1  read enable to memory stage
- mem_raddr  output  ADDR_W  word-aligned read address
- mem_wen  output  1  write enable to memory stage
- mem_waddr  output  ADDR_W  word-aligned write address
- mem_wdata  output  DATA_W  lane-shifted store data
- mem_wmask  output  8  byte mask; bits [7:4] always 0
- mem_rdata  input  DATA_W  read word, valid the cycle after the mem_ren edge
- resp_valid  output  1  result valid to WBU
- resp_ready  input  1  WBU accepts result
- resp_data  output  DATA_W  extended load value (0 for stores)
- resp_rd  output  5  destination register (0 for stores)
- resp_err  output  1  misaligned or illegal access

Behaviour:
- States: IDLE, LOAD_DATA, RESP. On reset: IDLE; resp_valid, resp_data, resp_rd, resp_err all 0.
- req_ready = (state==IDLE). Accept = req_valid & req_ready.
- Error check, evaluated on accept. Error if any of:
  - req_load and req_store both set, or neither set;
  - load funct3 not in {000,001,010,100,101};
  - store funct3 not in {000,001,010};
  - halfword with addr[0]!=0, or word with addr[1:0]!=0.
- Memory outputs are combinational; all are 0 unless accepting a legal request in IDLE.
- Legal load accept:
  - mem_ren=1, mem_raddr={addr[ADDR_W-1:2],2'b00}.
  - Capture funct3, addr[1:0], rd; next state LOAD_DATA.
- LOAD_DATA (exactly one cycle):
  - shifted = mem_rdata >> (8*off).
  - LB/LBU use shifted[7:0], sign/zero-extended; LH/LHU use shifted[15:0], sign/zero-extended; LW uses the full word.
  - Register the result into resp_data, set resp_valid=1, resp_err=0; next state RESP.
- Legal store accept:
  - mem_wen=1, mem_waddr aligned as above, mem_wdata = req_wdata << (8*off).
  - mem_wmask = {4'b0, base<<off}, where base = 0001 (SB), 0011 (SH), 1111 (SW).
  - Write commits at the accept edge. Next cycle: RESP with resp_valid=1, resp_data=0, resp_rd=0, resp_err=0.
- Illegal accept: no memory enable. Next cycle: RESP with resp_err=1, resp_data=0, resp_rd=0.
- RESP:
  - Outputs held stable while resp_ready=0.
  - On resp_valid & resp_ready: resp_valid drops to 0 and state returns to IDLE. The next request is accepted the cycle after.
- Latencies, where E0 is the accept edge:
  - Load: resp_valid high after E1, earliest consumption at E2.
  - Store and error: resp_valid high after E0.
  - Throughput is at most one access per 2 cycles for stores, 3 cycles for loads.
- Reset mid-operation: asynchronous return to IDLE; any pending response is dropped. A store whose accept edge already occurred is not undone.
- mem_rdata is ignored outside LOAD_DATA.

Test Plan:
- Memory word 0x80000010=0x8899AABB; LB at addr 0x80000011 -> mem_raddr=0x80000010, resp_valid after 2 edges, resp_data=0xFFFFFFAA; LBU at the same addr -> 0x000000AA.
- LH at 0x80000012 with word 0x80F01234 -> 0xFFFF80F0; LHU -> 0x000080F0; LW at 0x80000010 -> 0x80F01234.
- SB at 0x80000013, rs2=0x000000CD -> mem_wen=1, mem_waddr=0x80000010, mem_wdata=0xCD000000, mem_wmask=0x08; SH at offset 2 -> mask 0x0C; SW -> mask 0x0F.
- LW at 0x80000002 -> no mem_ren/mem_wen pulse, resp_err=1, resp_data=0; req_load=req_store=1 -> resp_err=1.
- Hold resp_ready=0 for 5 cycles after a load -> resp_valid/resp_data stable, req_ready=0, no new mem_ren; raise resp_ready -> IDLE next cycle.
- Assert rst low during LOAD_DATA -> resp_valid=0 immediately, req_ready=1 after rst deasserts, no stale response emitted.

Source files
------------

// File: rtl/ysyx_23060332_lsu.sv
// Load/store unit: accepts one EXU memory op at a time, issues word-aligned
// masked requests to the memory stage and returns extended load data to WBU.
module ysyx_23060332_lsu #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_load,
   input  logic              req_store,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [4:0]        req_rd,
   output logic              mem_ren,
   output logic [ADDR_W-1:0] mem_raddr,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [7:0]        mem_wmask,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic [4:0]        resp_rd,
   output logic              resp_err
);

   typedef enum logic [1:0] {IDLE, LOAD_DATA, RESP} state_t;

   state_t            state, state_nxt;
   logic [2:0]        ld_funct3;
   logic [1:0]        ld_off;
   logic [4:0]        ld_rd;
   logic              accept, req_err, f3_ok, align_ok;
   logic [3:0]        base_mask;
   logic [DATA_W-1:0] shifted, load_val;

   assign req_ready = (state == IDLE);
   assign accept    = req_valid & req_ready;

   always_comb begin
      f3_ok = 1'b0;
      if (req_load & ~req_store) begin
         case (req_funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
            default:                                f3_ok = 1'b0;
         endcase
      end else if (req_store & ~req_load) begin
         case (req_funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            default:                f3_ok = 1'b0;
         endcase
      end
   end

   // funct3[1:0] encodes access size for both loads and stores
   always_comb begin
      align_ok  = 1'b1;
      base_mask = 4'b0001;
      case (req_funct3[1:0])
         2'b01: begin
            align_ok  = ~req_addr[0];
            base_mask = 4'b0011;
         end
         2'b10: begin
            align_ok  = (req_addr[1:0] == 2'b00);
            base_mask = 4'b1111;
         end
         default: ;
      endcase
   end

   assign req_err = ~(f3_ok & align_ok);

   always_comb begin
      mem_ren   = 1'b0;
      mem_raddr = '0;
      mem_wen   = 1'b0;
      mem_waddr = '0;
      mem_wdata = '0;
      mem_wmask = '0;
      if (accept && !req_err) begin
         if (req_load) begin
            mem_ren   = 1'b1;
            mem_raddr = {req_addr[ADDR_W-1:2], 2'b00};
         end else begin
            mem_wen   = 1'b1;
            mem_waddr = {req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata = req_wdata << {req_addr[1:0], 3'b000};
            mem_wmask = {4'b0000, base_mask << req_addr[1:0]};
         end
      end
   end

   always_comb begin
      shifted = mem_rdata >> {ld_off, 3'b000};
      case (ld_funct3)
         3'b000:  load_val = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
         3'b100:  load_val = {{(DATA_W-8){1'b0}}, shifted[7:0]};
         3'b001:  load_val = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
         3'b101:  load_val = {{(DATA_W-16){1'b0}}, shifted[15:0]};
         default: load_val = shifted;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (accept) state_nxt = (req_err || !req_load) ? RESP : LOAD_DATA;
         LOAD_DATA: state_nxt = RESP;
         RESP:      if (resp_ready) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ld_funct3  <= '0;
         ld_off     <= '0;
         ld_rd      <= '0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_rd    <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               ld_funct3 <= req_funct3;
               ld_off    <= req_addr[1:0];
               ld_rd     <= req_rd;
               if (req_err || !req_load) begin
                  resp_valid <= 1'b1;
                  resp_data  <= '0;
                  resp_rd    <= '0;
                  resp_err   <= req_err;
               end
            end
            LOAD_DATA: begin
               resp_valid <= 1'b1;
               resp_data  <= load_val;
               resp_rd    <= ld_rd;
               resp_err   <= 1'b0;
            end
            RESP: if (resp_ready) resp_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_23060332_lsu.sv
// Scoreboard bench for ysyx_23060332_lsu: directed loads/stores/errors against
// a small word memory model, with backpressure and mid-load reset.
module tb_ysyx_23060332_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_load, req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic [4:0]  req_rd;
   logic        mem_ren, mem_wen;
   logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
   logic [7:0]  mem_wmask;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_data;
   logic [4:0]  resp_rd;

   typedef struct {
      int          id;
      logic [31:0] data;
      logic [4:0]  rd;
      logic        err;
   } exp_t;

   exp_t        q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          next_id  = 0;

   logic [31:0] mem [16];
   logic        set_en = 1'b0;
   logic [3:0]  set_idx;
   logic [31:0] set_val;

   always #5 clk = ~clk;

   ysyx_23060332_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
      .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_rd(req_rd),
      .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_wen(mem_wen),
      .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rdata(mem_rdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_rd(resp_rd), .resp_err(resp_err)
   );

   // Memory stage model: registered read, byte-masked write
   always @(posedge clk) begin
      mem_rdata <= mem_ren ? mem[mem_raddr[5:2]] : 32'hDEADBEEF;
      if (set_en) mem[set_idx] <= set_val;
      if (mem_wen)
         for (int b = 0; b < 4; b++)
            if (mem_wmask[b]) mem[mem_waddr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out, required completion within bound", name);
   endtask

   always @(negedge clk) begin
      if (rst_n && resp_valid && resp_ready) begin
         if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_resp: got resp_valid=1 data %h, required no response", resp_data);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk($sformatf("resp%0d_data", e.id), resp_data, e.data);
            chk($sformatf("resp%0d_rd", e.id), {27'd0, resp_rd}, {27'd0, e.rd});
            chk($sformatf("resp%0d_err", e.id), {31'd0, resp_err}, {31'd0, e.err});
         end
      end
   end

   task automatic set_word(input logic [3:0] idx, input logic [31:0] val);
      @(posedge clk); #1;
      set_en = 1'b1; set_idx = idx; set_val = val;
      @(posedge clk); #1;
      set_en = 1'b0;
   endtask

   task automatic do_req(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                         input logic [31:0] exp_data, input logic [4:0] exp_rd, input logic exp_err,
                         input logic [31:0] exp_wdata, input logic [3:0] exp_mask);
      int   n;
      exp_t e;
      @(posedge clk); #1;
      req_valid = 1'b1; req_load = ld; req_store = st; req_funct3 = f3;
      req_addr = addr; req_wdata = wd; req_rd = rd;
      @(negedge clk);
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         timeout("req_ready_wait");
         req_valid = 1'b0;
         return;
      end
      if (exp_err) begin
         chk("err_no_ren", {31'd0, mem_ren}, 32'd0);
         chk("err_no_wen", {31'd0, mem_wen}, 32'd0);
      end else if (ld) begin
         chk("ld_ren", {31'd0, mem_ren}, 32'd1);
         chk("ld_raddr", mem_raddr, {addr[31:2], 2'b00});
         chk("ld_no_wen", {31'd0, mem_wen}, 32'd0);
      end else begin
         chk("st_wen", {31'd0, mem_wen}, 32'd1);
         chk("st_waddr", mem_waddr, {addr[31:2], 2'b00});
         chk("st_wdata", mem_wdata, exp_wdata);
         chk("st_wmask", {24'd0, mem_wmask}, {28'd0, exp_mask});
         chk("st_no_ren", {31'd0, mem_ren}, 32'd0);
      end
      e.id = next_id; e.data = exp_data; e.rd = exp_rd; e.err = exp_err;
      next_id++;
      q.push_back(e);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("resp_latency", {31'd0, resp_valid}, (exp_err || !ld) ? 32'd1 : 32'd0);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         timeout("resp_drain");
         q.delete();
      end
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
      req_funct3 = '0; req_addr = '0; req_wdata = '0; req_rd = '0;
      resp_ready = 1'b1; set_idx = '0; set_val = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_resp_rd", {27'd0, resp_rd}, 32'd0);
      chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      rst_n = 1'b1;

      set_word(4'd4, 32'h8899AABB);
      do_req(1, 0, 3'b000, 32'h80000011, 0, 5'd5, 32'hFFFFFFAA, 5'd5, 0, 0, 0); wait_drain();
      do_req(1, 0, 3'b100, 32'h80000011, 0, 5'd6, 32'h000000AA, 5'd6, 0, 0, 0); wait_drain();
      set_word(4'd4, 32'h80F01234);
      do_req(1, 0, 3'b001, 32'h80000012, 0, 5'd7, 32'hFFFF80F0, 5'd7, 0, 0, 0); wait_drain();
      do_req(1, 0, 3'b101, 32'h80000012, 0, 5'd8, 32'h000080F0, 5'd8, 0, 0, 0); wait_drain();
      do_req(1, 0, 3'b010, 32'h80000010, 0, 5'd9, 32'h80F01234, 5'd9, 0, 0, 0); wait_drain();

      do_req(0, 1, 3'b000, 32'h80000013, 32'h000000CD, 5'd3, 0, 5'd0, 0, 32'hCD000000, 4'h8); wait_drain();
      do_req(1, 0, 3'b100, 32'h80000013, 0, 5'd10, 32'h000000CD, 5'd10, 0, 0, 0); wait_drain();
      do_req(0, 1, 3'b001, 32'h80000012, 32'h0000BEEF, 5'd4, 0, 5'd0, 0, 32'hBEEF0000, 4'hC); wait_drain();
      do_req(1, 0, 3'b001, 32'h80000012, 0, 5'd11, 32'hFFFFBEEF, 5'd11, 0, 0, 0); wait_drain();
      do_req(0, 1, 3'b010, 32'h80000010, 32'h11223344, 5'd2, 0, 5'd0, 0, 32'h11223344, 4'hF); wait_drain();
      do_req(1, 0, 3'b010, 32'h80000010, 0, 5'd12, 32'h11223344, 5'd12, 0, 0, 0); wait_drain();

      do_req(1, 0, 3'b010, 32'h80000002, 0, 5'd13, 0, 5'd0, 1, 0, 0); wait_drain();
      do_req(1, 1, 3'b010, 32'h80000010, 0, 5'd14, 0, 5'd0, 1, 0, 0); wait_drain();
      do_req(0, 0, 3'b010, 32'h80000010, 0, 5'd15, 0, 5'd0, 1, 0, 0); wait_drain();
      do_req(1, 0, 3'b011, 32'h80000010, 0, 5'd16, 0, 5'd0, 1, 0, 0); wait_drain();
      do_req(0, 1, 3'b100, 32'h80000010, 32'h1, 5'd17, 0, 5'd0, 1, 0, 0); wait_drain();
      do_req(1, 0, 3'b001, 32'h80000011, 0, 5'd18, 0, 5'd0, 1, 0, 0); wait_drain();
      do_req(0, 1, 3'b010, 32'h80000012, 32'h5, 5'd19, 0, 5'd0, 1, 0, 0); wait_drain();

      // Backpressure: response held while a new request waits
      resp_ready = 1'b0;
      do_req(1, 0, 3'b010, 32'h80000010, 0, 5'd20, 32'h11223344, 5'd20, 0, 0, 0);
      req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0; req_funct3 = 3'b010;
      req_addr = 32'h80000010; req_rd = 5'd21;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_valid", {31'd0, resp_valid}, 32'd1);
         chk("hold_data", resp_data, 32'h11223344);
         chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
         chk("hold_no_ren", {31'd0, mem_ren}, 32'd0);
      end
      req_valid = 1'b0;
      @(posedge clk); #1;
      resp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("release_req_ready", {31'd0, req_ready}, 32'd1);
      chk("release_valid_low", {31'd0, resp_valid}, 32'd0);
      wait_drain();

      // Reset while in LOAD_DATA drops the pending load
      @(posedge clk); #1;
      req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0; req_funct3 = 3'b010;
      req_addr = 32'h80000010; req_rd = 5'd22;
      @(negedge clk);
      chk("rstld_ren", {31'd0, mem_ren}, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rstld_busy", {31'd0, req_ready}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("rstld_valid", {31'd0, resp_valid}, 32'd0);
      chk("rstld_req_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rstld_no_stale", {31'd0, resp_valid}, 32'd0);
      end
      do_req(1, 0, 3'b010, 32'h80000010, 0, 5'd23, 32'h11223344, 5'd23, 0, 0, 0); wait_drain();

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
